// File: rtl/fifo_ctrl.sv
// fifo_ctrl: control stage of the 8-entry FIFO. It samples write/read requests,
// computes the next state, and holds the state register, occupancy counter and
// read/write pointers that drive the register file.
// Optional build macro FIFO_ERR_CNT_EN adds a saturating 8-bit error counter (err_cnt_o).
module fifo_ctrl #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned CNT_W  = 4
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              wr_en_i,
    input  logic              rd_en_i,
    output logic [2:0]        state_o,
    output logic [CNT_W-1:0]  data_count_o,
    output logic              we_o,
    output logic              re_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [ADDR_W-1:0] rd_addr_o
`ifdef FIFO_ERR_CNT_EN
    ,
    output logic [7:0]        err_cnt_o
`endif
);

    typedef enum logic [2:0] {
        StInit    = 3'b000,
        StNoOp    = 3'b001,
        StWrite   = 3'b010,
        StWrError = 3'b011,
        StRead    = 3'b100,
        StRdError = 3'b101
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    data_count_q, data_count_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic                full, empty;
    logic                we, re;

    // Next state, strobes, counter and pointer updates. The next state depends only
    // on the requests and the occupancy, so an unreachable code in state_q behaves
    // exactly like NO_OP at the following edge.
    always_comb begin
        full         = (data_count_q == CNT_W'(DEPTH));
        empty        = (data_count_q == '0);
        we           = reset_ni & wr_en_i & ~rd_en_i & ~full;
        re           = reset_ni & rd_en_i & ~wr_en_i & ~empty;
        state_d      = StNoOp;
        data_count_d = data_count_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;

        if (wr_en_i && !rd_en_i) begin
            state_d = full ? StWrError : StWrite;
        end else if (rd_en_i && !wr_en_i) begin
            state_d = empty ? StRdError : StRead;
        end

        if (we) begin
            data_count_d = data_count_q + CNT_W'(1);
            wr_ptr_d     = wr_ptr_q + ADDR_W'(1);  // wraps naturally 7 -> 0
        end else if (re) begin
            data_count_d = data_count_q - CNT_W'(1);
            rd_ptr_d     = rd_ptr_q + ADDR_W'(1);
        end
    end

    // State, occupancy and pointer registers.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= StInit;
            data_count_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            data_count_q <= data_count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

`ifdef FIFO_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // Count edges that land in an error state, saturating at 8'hFF.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if ((state_d == StWrError || state_d == StRdError) && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Error counter register.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt_o = err_cnt_q;
`endif

    assign state_o      = state_q;
    assign data_count_o = data_count_q;
    assign we_o         = we;
    assign re_o         = re;
    assign wr_addr_o    = wr_ptr_q;
    assign rd_addr_o    = rd_ptr_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Scoreboard bench for fifo_ctrl: stimulus pushes expected results computed from a
// count/pointer model; a monitor pops and compares each cycle the DUT is driven.
module tb_fifo_ctrl;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              wr_en = 1'b0;
    logic              rd_en = 1'b0;
    logic [2:0]        state;
    logic [CNT_W-1:0]  data_count;
    logic              we, re;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
`ifdef FIFO_ERR_CNT_EN
    logic [7:0]        err_cnt;
`endif

    fifo_ctrl #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk_i       (clk),
        .reset_ni    (reset_n),
        .wr_en_i     (wr_en),
        .rd_en_i     (rd_en),
        .state_o     (state),
        .data_count_o(data_count),
        .we_o        (we),
        .re_o        (re),
        .wr_addr_o   (wr_addr),
        .rd_addr_o   (rd_addr)
`ifdef FIFO_ERR_CNT_EN
        ,
        .err_cnt_o   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int we;   // strobe expected before the edge
        int re;
        int wa0;  // addresses before the edge
        int ra0;
        int st;   // values expected after the edge
        int cnt;
        int wa;
        int ra;
        int ec;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    // Reference model: occupancy, pointers as plain integers, error tally.
    int   m_cnt = 0;
    int   m_wp = 0;
    int   m_rp = 0;
    int   m_ec = 0;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Drive one request cycle and push what the FIFO rules say must happen.
    task automatic drive(input bit w, input bit r);
        exp_t e;
        @(negedge clk);
        wr_en = w;
        rd_en = r;
        e.wa0 = m_wp;
        e.ra0 = m_rp;
        e.we  = 0;
        e.re  = 0;
        if (w && !r) begin
            if (m_cnt < DEPTH) begin
                e.we = 1; e.st = 2; m_cnt++; m_wp = (m_wp + 1) % DEPTH;
            end else begin
                e.st = 3;
            end
        end else if (r && !w) begin
            if (m_cnt > 0) begin
                e.re = 1; e.st = 4; m_cnt--; m_rp = (m_rp + 1) % DEPTH;
            end else begin
                e.st = 5;
            end
        end else begin
            e.st = 1;
        end
        if ((e.st == 3 || e.st == 5) && m_ec < 255) m_ec++;
        e.cnt = m_cnt;
        e.wa  = m_wp;
        e.ra  = m_rp;
        e.ec  = m_ec;
        exp_q.push_back(e);
    endtask

    // Assert reset mid-cycle with a write pending; everything must clear at once.
    task automatic do_reset();
        @(posedge clk);
        #3;
        wr_en   = 1'b1;
        rd_en   = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("reset state", int'(state), 0);
        chk("reset count", int'(data_count), 0);
        chk("reset we", int'(we), 0);
        chk("reset re", int'(re), 0);
        chk("reset wr_addr", int'(wr_addr), 0);
        chk("reset rd_addr", int'(rd_addr), 0);
`ifdef FIFO_ERR_CNT_EN
        chk("reset err_cnt", int'(err_cnt), 0);
`endif
        m_cnt = 0; m_wp = 0; m_rp = 0; m_ec = 0;
        @(negedge clk);
        wr_en   = 1'b0;
        reset_n = 1'b1;
        #1;
        chk("init after release", int'(state), 0);
    endtask

    // Monitor: whenever a driven cycle is pending, sample strobes before the edge and
    // registered outputs after it, then compare against the oldest expectation.
    initial begin
        int s_we, s_re, s_wa, s_ra;
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() > 0 && reset_n) begin
                s_we = int'(we);
                s_re = int'(re);
                s_wa = int'(wr_addr);
                s_ra = int'(rd_addr);
                @(posedge clk);
                #1;
                e = exp_q.pop_front();
                chk("we", s_we, e.we);
                chk("re", s_re, e.re);
                chk("wr_addr pre", s_wa, e.wa0);
                chk("rd_addr pre", s_ra, e.ra0);
                chk("state", int'(state), e.st);
                chk("data_count", int'(data_count), e.cnt);
                chk("wr_addr", int'(wr_addr), e.wa);
                chk("rd_addr", int'(rd_addr), e.ra);
`ifdef FIFO_ERR_CNT_EN
                chk("err_cnt", int'(err_cnt), e.ec);
`endif
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        #12;
        do_reset();
        drive(0, 0);                                    // idle -> NO_OP

        for (int i = 0; i < 9; i++) drive(1, 0);        // fill, then write on full
        for (int i = 0; i < 9; i++) drive(0, 1);        // drain, then read on empty

        do_reset();                                     // wrap-around
        for (int i = 0; i < 5; i++) drive(1, 0);
        for (int i = 0; i < 5; i++) drive(0, 1);
        for (int i = 0; i < 6; i++) drive(1, 0);
        drive(0, 0);

        do_reset();                                     // simultaneous request at count 3
        for (int i = 0; i < 3; i++) drive(1, 0);
        drive(1, 1);
        drive(0, 0);

        do_reset();                                     // error tally: 3 + 2
        for (int i = 0; i < 3; i++) drive(0, 1);
        for (int i = 0; i < 10; i++) drive(1, 0);
        for (int i = 0; i < 8; i++) drive(0, 1);
        for (int i = 0; i < 300; i++) drive(0, 1);      // saturate error counter
        do_reset();

        for (int i = 0; i < 400; i++) begin              // random traffic
            int p;
            p = int'($urandom_range(0, 99));
            drive(p < 50, (p >= 40 && p < 90));
            if (i == 200) do_reset();                    // reset mid-burst
        end

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Upstream control stage of the 8-entry FIFO: samples write/read requests, runs the next-state logic, and holds the state register, occupancy counter and read/write pointers.
- Its state and data_count outputs drive the FIFO output-logic stage, which produces full/empty and the ack/err flags.
- Its we/re/wr_addr/rd_addr outputs drive the FIFO register file.

Parameters:
- DEPTH, 8, number of FIFO entries; must equal 2**ADDR_W.
- ADDR_W, 3, pointer width.
- CNT_W, 4, data_count width; must hold 0..DEPTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous reset, active low.
- wr_en  input  1  write request, sampled at rising clk.
- rd_en  input  1  read request, sampled at rising clk.
- state  output  3  registered FIFO state, to the output-logic stage.
- data_count  output  CNT_W  registered occupancy 0..DEPTH.
- we  output  1  register-file write strobe, combinational.
- re  output  1  register-file read strobe, combinational.
- wr_addr  output  ADDR_W  register-file write address, equal to wr_ptr.
- rd_addr  output  ADDR_W  register-file read address, equal to rd_ptr.

Behaviour:
- Interface is decided: one clock, clk; reset is asynchronous and active-low, reset_n.
- State encoding: INIT=3'b000, NO_OP=3'b001, WRITE=3'b010, WR_ERROR=3'b011, READ=3'b100, RD_ERROR=3'b101. Codes 110 and 111 are unreachable; if ever loaded, the next edge treats them as NO_OP.
- Reset (reset_n=0, any time, including mid-burst): state=INIT, data_count=0, wr_ptr=0, rd_ptr=0, effective immediately without a clock edge. we and re are forced to 0 while reset_n=0.
- Next state, evaluated from current data_count at each rising edge:
  - wr_en=1, rd_en=0, data_count<DEPTH -> WRITE.
  - wr_en=1, rd_en=0, data_count==DEPTH -> WR_ERROR.
  - rd_en=1, wr_en=0, data_count>0 -> READ.
  - rd_en=1, wr_en=0, data_count==0 -> RD_ERROR.
  - wr_en=rd_en=0 -> NO_OP.
  - wr_en=rd_en=1 -> NO_OP (simultaneous request rejected; no pointer or count change).
- INIT appears only after reset; it is left at the first edge with reset_n=1, following the table above.
- Accepted write (we=1 in the cycle):
  - At the edge: data_count+1, wr_ptr+1.
  - The register file stores data at wr_addr on that same edge.
  - state shows WRITE in the following cycle.
- Accepted read (re=1 in the cycle):
  - At the edge: data_count-1, rd_ptr+1.
  - The register file captures entry rd_addr into its output register on that edge, so read data is valid in the cycle where state=READ.
- Error states (WR_ERROR, RD_ERROR): data_count and both pointers hold.
- we = reset_n & wr_en & ~rd_en & (data_count!=DEPTH).
- re = reset_n & rd_en & ~wr_en & (data_count!=0).
- Pointers wrap modulo DEPTH via natural ADDR_W overflow (7 -> 0).
- data_count never exceeds DEPTH and never underflows below 0.
- Invariant: (wr_ptr - rd_ptr) mod DEPTH == data_count mod DEPTH.

Optional Feature:
- Macro: FIFO_ERR_CNT_EN.
- Defined:
  - Adds output err_cnt, 8 bits.
  - Increments at each edge whose next state is WR_ERROR or RD_ERROR.
  - Saturates at 8'hFF.
  - Cleared to 0 by reset_n=0.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: assert reset_n=0 mid-clock -> state=000, data_count=0, we=re=0 immediately. Release, then idle one edge -> state=001 (NO_OP).
- Fill: 8 consecutive write cycles -> data_count 1..8, state=010 each cycle, wr_addr 0..7. A 9th write -> we=0, state=011, data_count stays 8.
- Drain: from full, 8 read cycles -> data_count 7..0, rd_addr 0..7, state=100. A 9th read -> re=0, state=101, data_count stays 0.
- Wrap-around: write 5, read 5, write 6 -> wr_addr sequence 5,6,7,0,1,2; data_count=6; rd_addr=5.
- Simultaneous: wr_en=rd_en=1 at data_count=3 -> state=001, data_count=3, pointers unchanged, we=re=0.
- FIFO_ERR_CNT_EN: 3 reads on empty plus 2 writes on full -> err_cnt=5. 300 error cycles -> err_cnt=255. Reset -> err_cnt=0.
